// File: rtl/tape_encoder.sv
// Purpose  : serial tape encoder; each DATA_W-bit frame becomes start(0) + data LSB-first + stop(1)
//            as alternating pos/neg pulses at two tone rates ('0' = HALF0, '1' = HALF1 half-cycles).
// Latency  : the first pulse (tape_output_pos) is driven on the clock right after the accepting transfer.
// Backpres.: data_ready is high only in IDLE and on the final stop-bit clock, so frames can chain without a gap.
// Ports    : clk_cpu/rst (sync, active-high); data_in/data_valid/data_ready handshake;
//            busy, tape_output_pos, tape_output_neg are registered outputs.
module tape_encoder #(
    parameter int DATA_W        = 8,
    parameter int HALF0         = 1198,
    parameter int HALF1         = 599,
    parameter int PULSE_LEN     = 299,
    parameter int LEADER_CYCLES = 256
) (
    input  logic              clk_cpu,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              busy,
    output logic              tape_output_pos,
    output logic              tape_output_neg
);

    localparam int CW     = $clog2(HALF0 + 1);
    localparam int LW_RAW = $clog2(LEADER_CYCLES + 1);
    // A leader-less build still needs a 1-bit counter to keep the declarations legal.
    localparam int LW     = (LW_RAW < 1) ? 1 : LW_RAW;
    localparam int BW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADER,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;      // clocks elapsed in the current half-cycle
    logic [1:0]        r_half, w_half_nxt;    // half-cycle index within the current symbol
    logic [LW-1:0]     r_lead, w_lead_nxt;    // leader tone cycles completed
    logic [BW-1:0]     r_bit, w_bit_nxt;      // data bits completed
    logic [DATA_W-1:0] r_shift, w_shift_nxt;  // bit 0 is the bit on the wire during DATA
    logic              r_pos, r_neg, r_busy;
    logic              w_pos_nxt, w_neg_nxt;

    logic              w_tone1;
    logic [CW-1:0]     w_half_max;
    logic [1:0]        w_half_idx_max;
    logic              w_half_end;
    logic              w_sym_end;
    logic              w_last;
    logic              w_xfer;

    // Leader and stop are always '1' tone; START is always '0' tone.
    assign w_tone1 = (r_state == S_LEADER) || (r_state == S_STOP) ||
                     ((r_state == S_DATA) && r_shift[0]);
    assign w_half_max = w_tone1 ? CW'(HALF1 - 1) : CW'(HALF0 - 1);
    // A leader "symbol" is one tone cycle (2 halves); a data '1' is two tone cycles (4 halves).
    assign w_half_idx_max = ((r_state == S_LEADER) || !w_tone1) ? 2'd1 : 2'd3;
    assign w_half_end = (r_cnt == w_half_max);
    assign w_sym_end  = w_half_end && (r_half == w_half_idx_max);
    assign w_last     = (r_state == S_STOP) && w_sym_end;

    assign data_ready = !rst && ((r_state == S_IDLE) || w_last);
    assign w_xfer     = data_valid && data_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_half_nxt  = r_half;
        w_lead_nxt  = r_lead;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;

        if (r_state == S_IDLE) begin
            if (w_xfer) begin
                w_state_nxt = (LEADER_CYCLES == 0) ? S_START : S_LEADER;
                w_shift_nxt = data_in;
                w_cnt_nxt   = '0;
                w_half_nxt  = '0;
                w_lead_nxt  = '0;
                w_bit_nxt   = '0;
            end
        end else if (!w_half_end) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = '0;
            if (!w_sym_end) begin
                w_half_nxt = r_half + 1'b1;
            end else begin
                w_half_nxt = '0;
                case (r_state)
                    S_LEADER: begin
                        if (r_lead == LW'(LEADER_CYCLES - 1)) begin
                            w_state_nxt = S_START;
                            w_lead_nxt  = '0;
                        end else begin
                            w_lead_nxt = r_lead + 1'b1;
                        end
                    end
                    S_START: begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = '0;
                    end
                    S_DATA: begin
                        w_shift_nxt = r_shift >> 1;
                        if (r_bit == BW'(DATA_W - 1)) begin
                            w_state_nxt = S_STOP;
                            w_bit_nxt   = '0;
                        end else begin
                            w_bit_nxt = r_bit + 1'b1;
                        end
                    end
                    S_STOP: begin
                        // Back-to-back frames skip the leader.
                        if (w_xfer) begin
                            w_state_nxt = S_START;
                            w_shift_nxt = data_in;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_shift_nxt = '0;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // Outputs are decoded from next-state values so the registered pulse lines up
    // with the counter position it belongs to.
    assign w_pos_nxt = (w_state_nxt != S_IDLE) && (w_cnt_nxt < CW'(PULSE_LEN)) && !w_half_nxt[0];
    assign w_neg_nxt = (w_state_nxt != S_IDLE) && (w_cnt_nxt < CW'(PULSE_LEN)) &&  w_half_nxt[0];

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_half  <= '0;
            r_lead  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_half  <= w_half_nxt;
            r_lead  <= w_lead_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_pos   <= w_pos_nxt;
            r_neg   <= w_neg_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign busy            = r_busy;
    assign tape_output_pos = r_pos;
    assign tape_output_neg = r_neg;

endmodule

// File: tb/tb_tape_encoder.sv
// Purpose  : bench for tape_encoder; expected pulse trains come from a tone/half-cycle model.
// Latency  : checks outputs on the falling edge, one clock after each accepting transfer onward.
// Backpres.: drives data_valid held, pulsed and random to confirm transfers only on ready cycles.
module tb_tape_encoder;

    localparam int DW = 8;
    localparam int H0 = 8;
    localparam int H1 = 4;
    localparam int PL = 2;
    localparam int LC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din, din0;
    logic       vld, vld0;
    logic       rdy, bsy, pos, neg;
    logic       rdy0, bsy0, pos0, neg0;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_busy, cnt_pos_rise, cnt_neg_rise;

    bit q_pos[$];
    bit q_neg[$];
    bit q_rdy[$];

    always #5 clk = ~clk;

    tape_encoder #(.DATA_W(DW), .HALF0(H0), .HALF1(H1), .PULSE_LEN(PL), .LEADER_CYCLES(LC)) dut (
        .clk_cpu(clk), .rst(rst), .data_in(din), .data_valid(vld), .data_ready(rdy),
        .busy(bsy), .tape_output_pos(pos), .tape_output_neg(neg)
    );

    tape_encoder #(.DATA_W(DW), .HALF0(H0), .HALF1(H1), .PULSE_LEN(PL), .LEADER_CYCLES(0)) dut0 (
        .clk_cpu(clk), .rst(rst), .data_in(din0), .data_valid(vld0), .data_ready(rdy0),
        .busy(bsy0), .tape_output_pos(pos0), .tape_output_neg(neg0)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs == expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Model: a tone is nhalf half-cycles of half_len clocks, each opening with a PL-wide pulse,
    // even halves on pos and odd halves on neg.
    task automatic add_tone(input int half_len, input int nhalf);
        for (int h = 0; h < nhalf; h++)
            for (int c = 0; c < half_len; c++) begin
                q_pos.push_back((c < PL) && (h % 2 == 0));
                q_neg.push_back((c < PL) && (h % 2 == 1));
                q_rdy.push_back(1'b0);
            end
    endtask

    task automatic add_bit(input bit b);
        if (b) add_tone(H1, 4);
        else   add_tone(H0, 2);
    endtask

    task automatic add_frame(input logic [7:0] b, input int lead_cycles);
        for (int i = 0; i < lead_cycles; i++) add_tone(H1, 2);
        add_bit(1'b0);
        for (int i = 0; i < DW; i++) add_bit(b[i]);
        add_bit(1'b1);
        q_rdy[q_rdy.size() - 1] = 1'b1;
    endtask

    task automatic clear_model();
        q_pos.delete();
        q_neg.delete();
        q_rdy.delete();
    endtask

    task automatic drive(input bit which, input logic v, input logic [7:0] d);
        if (which) begin vld0 = v; din0 = d; end
        else       begin vld  = v; din  = d; end
    endtask

    task automatic accept(input bit which, input logic [7:0] b, input string tag);
        drive(which, 1'b1, b);
        @(negedge clk);
        chk({tag, "_rdy_idle"}, which ? rdy0 : rdy, 1'b1);
        @(posedge clk); #1;
        drive(which, 1'b0, b);
    endtask

    // mode 0: valid low; 1: valid held with nxt until the first ready cycle; 2: random valid/data
    task automatic play(input bit which, input int mode, input logic [7:0] nxt, input int n, input string tag);
        bit         seen = 1'b0;
        logic       v;
        logic [7:0] d;
        logic       op, on, ob, orr;
        logic       p_prev = 1'b0;
        logic       n_prev = 1'b0;
        cnt_busy = 0; cnt_pos_rise = 0; cnt_neg_rise = 0;
        for (int i = 0; i < n; i++) begin
            d = nxt;
            v = 1'b0;
            if (mode == 1) v = !seen;
            else if (mode == 2) begin
                v = q_rdy[i] ? 1'b0 : 1'($urandom_range(0, 1));
                d = 8'($urandom);
            end
            drive(which, v, d);
            @(negedge clk);
            op  = which ? pos0 : pos;
            on  = which ? neg0 : neg;
            ob  = which ? bsy0 : bsy;
            orr = which ? rdy0 : rdy;
            chk($sformatf("%s_pos[%0d]", tag, i), op, q_pos[i]);
            chk($sformatf("%s_neg[%0d]", tag, i), on, q_neg[i]);
            chk($sformatf("%s_busy[%0d]", tag, i), ob, 1'b1);
            chk($sformatf("%s_rdy[%0d]", tag, i), orr, q_rdy[i]);
            chk($sformatf("%s_overlap[%0d]", tag, i), op & on, 1'b0);
            if (op && !p_prev) cnt_pos_rise++;
            if (on && !n_prev) cnt_neg_rise++;
            if (ob) cnt_busy++;
            p_prev = op;
            n_prev = on;
            if (q_rdy[i]) seen = 1'b1;
            @(posedge clk); #1;
        end
        drive(which, 1'b0, 8'h00);
    endtask

    task automatic idle_chk(input bit which, input string tag);
        @(negedge clk);
        chk({tag, "_idle_pos"},  which ? pos0 : pos, 1'b0);
        chk({tag, "_idle_neg"},  which ? neg0 : neg, 1'b0);
        chk({tag, "_idle_busy"}, which ? bsy0 : bsy, 1'b0);
        chk({tag, "_idle_rdy"},  which ? rdy0 : rdy, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] rb;
        rst = 1'b1; vld = 1'b0; din = 8'h00; vld0 = 1'b0; din0 = 8'h00;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        vld = 1'b1; vld0 = 1'b1;
        @(negedge clk);
        chk("rst_rdy",  rdy,  1'b0);
        chk("rst_rdy0", rdy0, 1'b0);
        chk("rst_busy", bsy,  1'b0);
        chk("rst_pos",  pos,  1'b0);
        chk("rst_neg",  neg,  1'b0);
        @(posedge clk); #1;
        rst = 1'b0; vld = 1'b0; vld0 = 1'b0;
        idle_chk(1'b0, "post_rst");
        idle_chk(1'b1, "post_rst0");

        // Single 0xA5 with leader
        clear_model();
        add_frame(8'hA5, LC);
        accept(1'b0, 8'hA5, "a5");
        play(1'b0, 0, 8'h00, q_pos.size(), "a5");
        chk_int("a5_busy_clocks", cnt_busy, 176);
        chk_int("a5_pos_pulses", cnt_pos_rise, 17);
        chk_int("a5_neg_pulses", cnt_neg_rise, 17);
        idle_chk(1'b0, "a5");

        // 0x00: all '0' tone except the stop bit
        clear_model();
        add_frame(8'h00, LC);
        accept(1'b0, 8'h00, "z");
        play(1'b0, 0, 8'h00, q_pos.size(), "z");
        chk_int("z_busy_clocks", cnt_busy, 176);
        idle_chk(1'b0, "z");

        // Held valid: 0x12 then 0x34 back-to-back, no leader on the second
        clear_model();
        add_frame(8'h12, LC);
        add_frame(8'h34, 0);
        accept(1'b0, 8'h12, "b2b");
        play(1'b0, 1, 8'h34, q_pos.size(), "b2b");
        chk_int("b2b_busy_clocks", cnt_busy, 336);
        idle_chk(1'b0, "b2b");

        // Reset 50 clocks into a frame
        clear_model();
        add_frame(8'hC3, LC);
        accept(1'b0, 8'hC3, "mrst");
        play(1'b0, 0, 8'h00, 50, "mrst");
        rst = 1'b1;
        vld = 1'b1;
        @(negedge clk);
        chk("mrst_rdy_in_rst", rdy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        vld = 1'b0;
        @(negedge clk);
        chk("mrst_pos_after", pos, 1'b0);
        chk("mrst_neg_after", neg, 1'b0);
        chk("mrst_busy_after", bsy, 1'b0);
        chk("mrst_rdy_after", rdy, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("mrst_quiet_pos[%0d]", i), pos, 1'b0);
            chk($sformatf("mrst_quiet_neg[%0d]", i), neg, 1'b0);
            chk($sformatf("mrst_quiet_busy[%0d]", i), bsy, 1'b0);
            @(posedge clk); #1;
        end

        // Random data_valid/data_in noise during frames
        for (int f = 0; f < 3; f++) begin
            rb = 8'($urandom);
            clear_model();
            add_frame(rb, LC);
            accept(1'b0, rb, $sformatf("rnd%0d", f));
            play(1'b0, 2, 8'h00, q_pos.size(), $sformatf("rnd%0d", f));
            chk_int($sformatf("rnd%0d_busy_clocks", f), cnt_busy, 176);
            idle_chk(1'b0, $sformatf("rnd%0d", f));
        end

        // No-leader instance, 0xFF
        clear_model();
        add_frame(8'hFF, 0);
        accept(1'b1, 8'hFF, "nl");
        play(1'b1, 0, 8'h00, q_pos.size(), "nl");
        chk_int("nl_busy_clocks", cnt_busy, 160);
        idle_chk(1'b1, "nl");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
